// File: rtl/acc_alu_seq_if.sv
// Bus-side signal bundle for acc_alu_seq: operand/command issue, handshake,
// accumulator view, flags and the shared tri-state output bus.
interface acc_alu_seq_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] data_in;
  logic [2:0]       command;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] acc;
  logic             out_en;
  wire  [WIDTH-1:0] out;
  logic             carry;
  logic             zero;

  modport master (
    output data_in, command, start, out_en,
    input  busy, done, acc, out, carry, zero
  );

  modport slave (
    input  data_in, command, start, out_en,
    output busy, done, acc, out, carry, zero
  );
endinterface

// File: rtl/acc_alu_seq.sv
// Accumulator datapath with single-cycle ALU ops and a WIDTH-cycle
// shift-add multiply, driving the shared output bus through a tri-state.
//
// state  | meaning
// S_IDLE | waiting for start; single-cycle ops complete on the start edge
// S_MUL  | shift-add multiply in progress, one multiplier bit per edge
module acc_alu_seq #(
  parameter int WIDTH = 4
) (
  input logic        Clk,
  input logic        reset,
  acc_alu_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_CMP  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [CW-1:0]      cnt;
  logic               carry_q;
  logic               zero_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  always_comb begin
    sum  = {1'b0, acc_q} + {1'b0, bus.data_in};
    diff = {1'b0, acc_q} - {1'b0, bus.data_in};
    prod_next = prod;
    if (mplier[0])
      prod_next = prod + ({{WIDTH{1'b0}}, mcand} << cnt);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      acc_q   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            done_q <= 1'b1;
            case (bus.command)
              OP_CMP: begin
                carry_q <= diff[WIDTH];
                zero_q  <= (diff[WIDTH-1:0] == '0);
              end
              OP_LOAD: begin
                acc_q   <= bus.data_in;
                carry_q <= 1'b0;
                zero_q  <= 1'b0;
              end
              OP_ADD: begin
                {carry_q, acc_q} <= sum;
                zero_q <= (sum[WIDTH-1:0] == '0);
              end
              OP_NAND: begin
                acc_q   <= ~(acc_q & bus.data_in);
                carry_q <= 1'b0;
                zero_q  <= 1'b0;
              end
              OP_SUB: begin
                {carry_q, acc_q} <= diff;
                zero_q <= (diff[WIDTH-1:0] == '0);
              end
              OP_MUL: begin
                // completion is signalled from S_MUL, not on the start edge
                done_q <= 1'b0;
                mcand  <= bus.data_in;
                mplier <= acc_q;
                prod   <= '0;
                cnt    <= '0;
                busy_q <= 1'b1;
                state  <= S_MUL;
              end
              default: begin
                carry_q <= 1'b0;
                zero_q  <= 1'b0;
              end
            endcase
          end
        end
        S_MUL: begin
          prod   <= prod_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            acc_q   <= prod_next[WIDTH-1:0];
            carry_q <= |prod_next[2*WIDTH-1:WIDTH];
            zero_q  <= (prod_next[WIDTH-1:0] == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.acc   = acc_q;
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out   = bus.out_en ? acc_q : {WIDTH{1'bz}};

endmodule
